// File: rtl/adder_2bit_pkg.sv
// Shared arithmetic constants: the legal operand-width range for the ripple adders.
package adder_2bit_pkg;

  localparam int ARITH_WIDTH_MIN = 1;
  localparam int ARITH_WIDTH_MAX = 16;

  function automatic bit width_legal(input int width);
    return (width >= ARITH_WIDTH_MIN) && (width <= ARITH_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/adder_2bit_full_adder.sv
// One-bit full adder cell; the ripple chain in adder_2bit is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/adder_2bit.sv
// Unsigned ripple-carry adder {Carry, Sum} = A + B with an optional output register stage.
module adder_2bit
  import adder_2bit_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             out_valid
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $fatal(1, "adder_2bit: WIDTH=%0d outside %0d..%0d", WIDTH, ARITH_WIDTH_MIN, ARITH_WIDTH_MAX);
  end

  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_next;

  assign carry_chain[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder u_fa (
        .a    (A[gi]),
        .b    (B[gi]),
        .cin  (carry_chain[gi]),
        .s    (sum_next[gi]),
        .cout (carry_chain[gi+1])
      );
    end
  endgenerate

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    // Data captures every edge; out_valid alone qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg   <= '0;
        carry_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else begin
        sum_reg   <= sum_next;
        carry_reg <= carry_chain[WIDTH];
        valid_reg <= in_valid;
      end
    end

    assign Sum       = sum_reg;
    assign Carry     = carry_reg;
    assign out_valid = valid_reg;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign Sum            = sum_next;
    assign Carry          = carry_chain[WIDTH];
    assign out_valid      = in_valid;
  end

endmodule

// File: tb/tb_adder_2bit.sv
// Bench for adder_2bit: registered 2-bit, combinational 2-bit and registered 8-bit instances.
module tb_adder_2bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       iv2 = 1'b0, carry2, ov2;
  logic [1:0] ac = '0, bc = '0, sumc;
  logic       ivc = 1'b0, carryc, ovc;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       iv8 = 1'b0, carry8, ov8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_2bit #(.WIDTH(2), .REG_OUT(1'b1)) dut_r2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .in_valid(iv2),
    .Sum(sum2), .Carry(carry2), .out_valid(ov2)
  );

  adder_2bit #(.WIDTH(2), .REG_OUT(1'b0)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .A(ac), .B(bc), .in_valid(ivc),
    .Sum(sumc), .Carry(carryc), .out_valid(ovc)
  );

  adder_2bit #(.WIDTH(8), .REG_OUT(1'b1)) dut_r8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv8),
    .Sum(sum8), .Carry(carry8), .out_valid(ov8)
  );

  // Reference: plain integer addition split at 2**width.
  function automatic int ref_sum(input int a, input int b, input int width);
    return (a + b) % (1 << width);
  endfunction

  function automatic int ref_carry(input int a, input int b, input int width);
    return (a + b) / (1 << width);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; a2 = 2'd3; b2 = 2'd3; iv2 = 1'b1;
    a8 = 8'd255; b8 = 8'd255; iv8 = 1'b1;
    #2;
    checks++;
    if (sum2 !== 2'd0 || carry2 !== 1'b0 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_w2 got sum=%0d carry=%0d ov=%0d want 0 0 0", sum2, carry2, ov2);
    end else $display("ok reset_hold_w2");
    checks++;
    if (sum8 !== 8'd0 || carry8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_w8 got sum=%0d carry=%0d ov=%0d want 0 0 0", sum8, carry8, ov8);
    end else $display("ok reset_hold_w8");
    @(posedge clk); #1;
    checks++;
    if (sum2 !== 2'd0 || carry2 !== 1'b0 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge_w2 got sum=%0d carry=%0d ov=%0d want 0 0 0", sum2, carry2, ov2);
    end else $display("ok reset_edge_w2");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sum2 !== 2'd2 || carry2 !== 1'b1 || ov2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_w2 got sum=%0d carry=%0d ov=%0d want 2 1 1", sum2, carry2, ov2);
    end else $display("ok reset_release_w2 sum=2 carry=1");
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 16; i++) begin
      int ea, eb;
      ea = i / 4; eb = i % 4;
      @(negedge clk); a2 = 2'(ea); b2 = 2'(eb); iv2 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (int'(sum2) !== ref_sum(ea, eb, 2) || int'(carry2) !== ref_carry(ea, eb, 2) || ov2 !== 1'b1) begin
        errors++;
        $display("FAIL exhaustive a=%0d b=%0d got carry=%0d sum=%0d ov=%0d want carry=%0d sum=%0d ov=1",
                 ea, eb, carry2, sum2, ov2, ref_carry(ea, eb, 2), ref_sum(ea, eb, 2));
      end else $display("ok exhaustive a=%0d b=%0d carry=%0d sum=%0d", ea, eb, carry2, sum2);
    end
  endtask

  task automatic test_streaming;
    int pa, pb;
    logic pv;
    pa = int'(a2); pb = int'(b2); pv = iv2;
    for (int k = 0; k < 20; k++) begin
      int ea, eb;
      logic ev;
      ea = int'($urandom_range(0, 3)); eb = int'($urandom_range(0, 3)); ev = (k % 2 == 0);
      @(negedge clk); a2 = 2'(ea); b2 = 2'(eb); iv2 = ev;
      #1;
      // Before the edge the output must still hold the previous cycle's result.
      checks++;
      if (int'(sum2) !== ref_sum(pa, pb, 2) || int'(carry2) !== ref_carry(pa, pb, 2) || ov2 !== pv) begin
        errors++;
        $display("FAIL stream_hold k=%0d got carry=%0d sum=%0d ov=%0d want carry=%0d sum=%0d ov=%0d",
                 k, carry2, sum2, ov2, ref_carry(pa, pb, 2), ref_sum(pa, pb, 2), pv);
      end
      @(posedge clk); #1;
      checks++;
      if (int'(sum2) !== ref_sum(ea, eb, 2) || int'(carry2) !== ref_carry(ea, eb, 2) || ov2 !== ev) begin
        errors++;
        $display("FAIL stream k=%0d a=%0d b=%0d got carry=%0d sum=%0d ov=%0d want carry=%0d sum=%0d ov=%0d",
                 k, ea, eb, carry2, sum2, ov2, ref_carry(ea, eb, 2), ref_sum(ea, eb, 2), ev);
      end else $display("ok stream k=%0d a=%0d b=%0d ov=%0d", k, ea, eb, ov2);
      pa = ea; pb = eb; pv = ev;
    end
  endtask

  task automatic test_midstream_reset;
    @(negedge clk); a2 = 2'd3; b2 = 2'd2; iv2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov2 !== 1'b1 || sum2 !== 2'd1 || carry2 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got carry=%0d sum=%0d ov=%0d want 1 1 1", carry2, sum2, ov2);
    end else $display("ok midreset_pre");
    #1; rst_n = 1'b0;
    #1;
    checks++;
    if (ov2 !== 1'b0 || sum2 !== 2'd0 || carry2 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got carry=%0d sum=%0d ov=%0d want 0 0 0", carry2, sum2, ov2);
    end else $display("ok midreset_async cleared before edge");
    @(negedge clk); rst_n = 1'b1; a2 = 2'd1; b2 = 2'd1; iv2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov2 !== 1'b1 || sum2 !== 2'd2 || carry2 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first got carry=%0d sum=%0d ov=%0d want 0 2 1", carry2, sum2, ov2);
    end else $display("ok midreset_first");
  endtask

  task automatic test_comb;
    int ta[4] = '{2, 3, 3, 0};
    int tb[4] = '{1, 1, 3, 0};
    for (int k = 0; k < 12; k++) begin
      int ea, eb;
      logic ev;
      if (k < 4) begin
        ea = ta[k]; eb = tb[k];
      end else begin
        ea = int'($urandom_range(0, 3)); eb = int'($urandom_range(0, 3));
      end
      ev = (k % 3 != 0);
      rst_n = (k < 8);
      ac = 2'(ea); bc = 2'(eb); ivc = ev;
      #1;
      checks++;
      if (int'(sumc) !== ref_sum(ea, eb, 2) || int'(carryc) !== ref_carry(ea, eb, 2) || ovc !== ev) begin
        errors++;
        $display("FAIL comb a=%0d b=%0d rst_n=%0d got carry=%0d sum=%0d ov=%0d want carry=%0d sum=%0d ov=%0d",
                 ea, eb, rst_n, carryc, sumc, ovc, ref_carry(ea, eb, 2), ref_sum(ea, eb, 2), ev);
      end else $display("ok comb a=%0d b=%0d carry=%0d sum=%0d", ea, eb, carryc, sumc);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_width8;
    int ta[3] = '{255, 200, 128};
    int tb[3] = '{1, 55, 128};
    for (int k = 0; k < 13; k++) begin
      int ea, eb;
      if (k < 3) begin
        ea = ta[k]; eb = tb[k];
      end else begin
        ea = int'($urandom_range(0, 255)); eb = int'($urandom_range(0, 255));
      end
      @(negedge clk); a8 = 8'(ea); b8 = 8'(eb); iv8 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (int'(sum8) !== ref_sum(ea, eb, 8) || int'(carry8) !== ref_carry(ea, eb, 8) || ov8 !== 1'b1) begin
        errors++;
        $display("FAIL w8 a=%0d b=%0d got carry=%0d sum=%0d ov=%0d want carry=%0d sum=%0d ov=1",
                 ea, eb, carry8, sum8, ov8, ref_carry(ea, eb, 8), ref_sum(ea, eb, 8));
      end else $display("ok w8 a=%0d b=%0d carry=%0d sum=%0d", ea, eb, carry8, sum8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exhaustive();
    test_streaming();
    test_midstream_reset();
    test_comb();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_2bit.md
Name: adder_2bit

Overview:
- Unsigned ripple-carry adder, WIDTH-bit operands (default 2), with an optional output register stage.
- Produces {Carry, Sum} = A + B.
- Used as a small arithmetic leaf in datapaths and as a bring-up/teaching block for the verification flow.
- Single clock domain. Asynchronous active-low reset.

Parameters:
- WIDTH, 2, operand and sum width in bits; legal range 1..16.
- REG_OUT, 1: 1 = outputs registered (latency 1 cycle); 0 = purely combinational path, and clk/rst_n are unused.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- in_valid  input  1  A/B are valid this cycle.
- Sum  output  WIDTH  low WIDTH bits of A+B.
- Carry  output  1  carry out of the MSB (bit WIDTH of A+B).
- out_valid  output  1  Sum/Carry correspond to a valid input.

Behaviour:
- Arithmetic: {Carry, Sum} = zero-extend(A) + zero-extend(B), computed at WIDTH+1 bits.
  - No saturation.
  - Carry is the only overflow indication.
- Structure: a chain of WIDTH full_adder cells; cell 0 carry-in is tied to 0; Carry is the carry-out of cell WIDTH-1.
- Reset behaviour (REG_OUT=1):
  - While rst_n=0, Sum=0, Carry=0 and out_valid=0, immediately and independent of clk.
  - Deassertion takes effect at the next rising clk edge.
- Registered mode (REG_OUT=1):
  - At each rising clk edge, Sum/Carry capture the combinational result of the current A/B.
  - out_valid captures in_valid.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle; there is no backpressure.
  - Sum/Carry update on every edge regardless of in_valid (no data gating).
  - Consumers qualify results with out_valid.
- Combinational mode (REG_OUT=0):
  - Sum/Carry follow A/B with zero cycles of latency; out_valid = in_valid.
  - rst_n has no effect.
- Reset asserted mid-stream (REG_OUT=1): any in-flight result is dropped and out_valid goes 0 asynchronously. The first valid result after release is the one captured at the first edge with rst_n=1.
- X on A/B: X propagation is permitted on Sum/Carry. out_valid must never be X after reset.
- Boundary cases:
  - all-ones + all-ones gives Carry=1, Sum = all-ones minus 1.
  - 0 + 0 gives 0 with Carry=0.
  - all-ones + 1 gives Carry=1, Sum=0 (wrap).

Decomposition:
- Shared package: no typedefs are required. The WIDTH legal-range constants (MIN 1, MAX 16) belong in the common arith package.
- Sub-module: full_adder (a, b, cin -> s, cout), instantiated WIDTH times by a generate loop.
- Elaboration-time check: an out-of-range WIDTH is a fatal error.

Test Plan:
- Reset: hold rst_n=0 with A=3, B=3, in_valid=1 -> Sum=0, Carry=0, out_valid=0; release, then 1 edge later -> Sum=2, Carry=1, out_valid=1.
- Exhaustive, WIDTH=2, REG_OUT=1: drive all 16 {A,B} combinations, one per cycle, from 0000 to 1111 -> each result one cycle later. Examples: 0001->001, 0111->100, 1011->101, 1111->110.
- Streaming: change A/B on every cycle with in_valid alternating 1/0 -> out_valid is the same pattern delayed by 1 cycle, and every valid result is correct.
- Mid-stream reset: assert rst_n=0 between clock edges while out_valid=1 -> outputs clear immediately, before any clk edge.
- REG_OUT=0, WIDTH=2: A=2, B=1 -> {Carry,Sum}=011 in the same timestep; A=3, B=1 -> 100.
- WIDTH=8, REG_OUT=1: A=255, B=1 -> Sum=0, Carry=1. A=200, B=55 -> Sum=255, Carry=0. A=128, B=128 -> Sum=0, Carry=1.
